univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register length in bits; legal range 2..32.
REQ-002 Parameter CNT_W, default $clog2(WIDTH), shift-counter width; derived from WIDTH, not overridden.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  clock enable; 0 freezes all state.
REQ-006 Port mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 Port sin_r  input  1  serial input entering the MSB on shift right.
REQ-008 Port sin_l  input  1  serial input entering the LSB on shift left.
REQ-009 Port pin  input  WIDTH  parallel load data.
REQ-010 Port pout  output  WIDTH  register contents, registered.
REQ-011 Port sout_r  output  1  equals pout[0], combinational from the register.
REQ-012 Port sout_l  output  1  equals pout[WIDTH-1], combinational from the register.
REQ-013 Port shift_cnt  output  CNT_W  number of shifts since the last load, reset or wrap.
REQ-014 Port word_valid  output  1  registered one-cycle pulse: WIDTH consecutive shifts have completed.

Function
REQ-015 Every operation takes effect on the rising clk edge when en=1; pout shows the result in the following cycle.
REQ-016 If en=0, the block holds pout and shift_cnt, and drives word_valid to 0 on that edge.
REQ-017 Mode 00 (hold) leaves pout and shift_cnt unchanged and drives word_valid to 0.
REQ-018 Mode 01 (shift right) sets pout to {sin_r, pout[WIDTH-1:1]}.
REQ-019 Mode 10 (shift left) sets pout to {pout[WIDTH-2:0], sin_l}.
REQ-020 Mode 11 (load) sets pout to pin, clears shift_cnt to 0 and drives word_valid to 0.
REQ-021 Each shift (mode 01 or 10, en=1) increments shift_cnt; from WIDTH-1 the count wraps to 0 and word_valid is set to 1 for exactly the next cycle.
REQ-022 Any edge that does not perform the wrapping shift drives word_valid to 0, so back-to-back words give one pulse every WIDTH cycles.
REQ-023 Mixed directions count together: changing direction mid-word neither clears nor skips shift_cnt.
REQ-024 A load on the same edge that would have wrapped takes priority: no word_valid pulse, shift_cnt=0.
REQ-025 Arithmetic: shift_cnt is unsigned modulo WIDTH and never holds a value >= WIDTH.

Reset
REQ-026 Reset_n=0 asynchronously forces pout to 0, shift_cnt to 0 and word_valid to 0, regardless of clk or en.
REQ-027 Reset asserted mid-word discards the partial word: no word_valid pulse follows, and counting restarts from 0.
REQ-028 Reset is released synchronously to clk; the first edge with Reset_n=1 performs a normal operation.

Structure
REQ-029 A shared package shift_reg_pkg holds the mode encodings MODE_HOLD, MODE_SHR, MODE_SHL and MODE_LOAD, plus their typedef.
REQ-030 A single sub-module shift_bit_cnt implements the modulo-WIDTH counter with inputs inc and clr and outputs cnt and wrap_pulse; the data path stays in the top module.

Verification (WIDTH=4)
REQ-031 Load pin=4'b1010, then hold for 3 cycles -> pout=1010 throughout, shift_cnt=0, word_valid=0.
REQ-032 After reset, shift right 4 cycles with sin_r=1,0,1,1 -> pout=1101, sout_r=1, and word_valid high exactly in the cycle after the 4th shift.
REQ-033 Load 4'b0001, then shift left 2 with sin_l=0 -> pout=0100 and shift_cnt=2; then shift right 2 with sin_r=1 -> pout=1101, word_valid pulses.
REQ-034 Shift 3 times, deassert en for 2 cycles, then shift once more -> shift_cnt holds 3 while en=0, then the pulse fires after the 4th shift.
REQ-035 Shift 3 times, then load on the 4th edge -> shift_cnt=0, no word_valid pulse.
REQ-036 Shift 2 times, pulse Reset_n low between edges -> pout=0 and shift_cnt=0 immediately; the next 4 shifts produce one pulse.

Source files
------------

// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_pkg
// Description : Mode encodings shared by the universal shift register slice.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : shift_bit_cnt
// Description : Modulo-WIDTH shift counter with a registered wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_bit_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap_pulse
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_wrap;
    logic             w_wrap;

    // A clear on the same edge suppresses the wrap, so a load always wins.
    assign w_wrap = inc & ~clr & (r_cnt == c_MAX);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap;
            if (clr) begin
                r_cnt <= '0;
            end else if (inc) begin
                r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    assign cnt        = r_cnt;
    assign wrap_pulse = r_wrap;

endmodule : shift_bit_cnt
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal shift register (hold/shift right/shift left/load)
//               with a word-complete pulse every WIDTH shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_valid
);

    mode_e            w_mode;
    logic             w_shift;
    logic             w_load;
    logic [WIDTH-1:0] r_pout;

    assign w_mode  = mode_e'(mode);
    assign w_shift = en & ((w_mode == MODE_SHR) | (w_mode == MODE_SHL));
    assign w_load  = en & (w_mode == MODE_LOAD);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pout <= '0;
        end else if (en) begin
            case (w_mode)
                MODE_SHR:  r_pout <= {sin_r, r_pout[WIDTH-1:1]};
                MODE_SHL:  r_pout <= {r_pout[WIDTH-2:0], sin_l};
                MODE_LOAD: r_pout <= pin;
                default:   r_pout <= r_pout;
            endcase
        end
    end

    shift_bit_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .inc        (w_shift),
        .clr        (w_load),
        .cnt        (shift_cnt),
        .wrap_pulse (word_valid)
    );

    assign pout   = r_pout;
    assign sout_r = r_pout[0];
    assign sout_l = r_pout[WIDTH-1];

endmodule : univ_shift_reg
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Directed self-checking bench for univ_shift_reg, WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;
    import shift_reg_pkg::*;

    localparam int c_WIDTH = 4;
    localparam int c_CNT_W = $clog2(c_WIDTH);

    logic               clk;
    logic               Reset_n;
    logic               en;
    logic [1:0]         mode;
    logic               sin_r;
    logic               sin_l;
    logic [c_WIDTH-1:0] pin;
    logic [c_WIDTH-1:0] pout;
    logic               sout_r;
    logic               sout_l;
    logic [c_CNT_W-1:0] shift_cnt;
    logic               word_valid;

    int n_checks = 0;
    int n_errors = 0;

    univ_shift_reg #(
        .WIDTH (c_WIDTH)
    ) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pin        (pin),
        .pout       (pout),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .shift_cnt  (shift_cnt),
        .word_valid (word_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_state(input string tag, input logic [3:0] p, input int c, input logic w);
        check({tag, ".pout"}, 32'(pout), 32'(p));
        check({tag, ".cnt"}, 32'(shift_cnt), 32'(c));
        check({tag, ".wv"}, 32'(word_valid), 32'(w));
    endtask

    // Apply one operation and sample 1 time unit after the edge.
    task automatic op(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                      input logic [3:0] p);
        en = e; mode = m; sin_r = sr; sin_l = sl; pin = p;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_pulse(input string tag);
        Reset_n = 1'b0;
        #2;
        exp_state(tag, 4'b0000, 0, 1'b0);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0; en = 1'b1; mode = MODE_SHR; sin_r = 1'b1; sin_l = 1'b1; pin = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        exp_state("reset", 4'b0000, 0, 1'b0);
        Reset_n = 1'b1;

        // Load then hold
        op(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1010);
        exp_state("load", 4'b1010, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            op(1'b1, MODE_HOLD, 1'b1, 1'b1, 4'b0101);
            exp_state("hold", 4'b1010, 0, 1'b0);
        end

        // Shift right a full word after reset
        async_reset_pulse("rst2");
        op(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
        exp_state("shr1", 4'b1000, 1, 1'b0);
        op(1'b1, MODE_SHR, 1'b0, 1'b0, 4'b0000);
        exp_state("shr2", 4'b0100, 2, 1'b0);
        op(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
        exp_state("shr3", 4'b1010, 3, 1'b0);
        op(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
        exp_state("shr4", 4'b1101, 0, 1'b1);
        check("shr4.sout_r", 32'(sout_r), 32'd1);
        check("shr4.sout_l", 32'(sout_l), 32'd1);
        op(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'b0000);
        exp_state("shr_after", 4'b1101, 0, 1'b0);

        // Mixed directions within one word
        op(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b0001);
        exp_state("mix_ld", 4'b0001, 0, 1'b0);
        op(1'b1, MODE_SHL, 1'b1, 1'b0, 4'b0000);
        exp_state("shl1", 4'b0010, 1, 1'b0);
        op(1'b1, MODE_SHL, 1'b1, 1'b0, 4'b0000);
        exp_state("shl2", 4'b0100, 2, 1'b0);
        op(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
        exp_state("mix3", 4'b1010, 3, 1'b0);
        op(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
        exp_state("mix4", 4'b1101, 0, 1'b1);

        // Enable low mid-word freezes count and data
        op(1'b1, MODE_SHR, 1'b0, 1'b0, 4'b0000);
        exp_state("en1", 4'b0110, 1, 1'b0);
        op(1'b1, MODE_SHR, 1'b0, 1'b0, 4'b0000);
        exp_state("en2", 4'b0011, 2, 1'b0);
        op(1'b1, MODE_SHR, 1'b0, 1'b0, 4'b0000);
        exp_state("en3", 4'b0001, 3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            op(1'b0, MODE_SHR, 1'b1, 1'b1, 4'b1111);
            exp_state("en_off", 4'b0001, 3, 1'b0);
        end
        op(1'b1, MODE_SHR, 1'b0, 1'b0, 4'b0000);
        exp_state("en4", 4'b0000, 0, 1'b1);

        // Load on the would-be wrapping edge
        op(1'b1, MODE_SHL, 1'b0, 1'b1, 4'b0000);
        exp_state("ldw1", 4'b0001, 1, 1'b0);
        op(1'b1, MODE_SHL, 1'b0, 1'b1, 4'b0000);
        exp_state("ldw2", 4'b0011, 2, 1'b0);
        op(1'b1, MODE_SHL, 1'b0, 1'b0, 4'b0000);
        exp_state("ldw3", 4'b0110, 3, 1'b0);
        op(1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1001);
        exp_state("ldw4", 4'b1001, 0, 1'b0);
        op(1'b1, MODE_HOLD, 1'b0, 1'b0, 4'b0000);
        exp_state("ldw5", 4'b1001, 0, 1'b0);

        // Reset mid-word discards the partial word
        op(1'b1, MODE_SHL, 1'b0, 1'b1, 4'b0000);
        exp_state("rmw1", 4'b0011, 1, 1'b0);
        op(1'b1, MODE_SHL, 1'b0, 1'b1, 4'b0000);
        exp_state("rmw2", 4'b0111, 2, 1'b0);
        async_reset_pulse("rmw_rst");
        op(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
        exp_state("rmw_s1", 4'b1000, 1, 1'b0);
        op(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
        exp_state("rmw_s2", 4'b1100, 2, 1'b0);
        op(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
        exp_state("rmw_s3", 4'b1110, 3, 1'b0);
        op(1'b1, MODE_SHR, 1'b1, 1'b0, 4'b0000);
        exp_state("rmw_s4", 4'b1111, 0, 1'b1);

        // Back-to-back word: exactly one pulse per WIDTH shifts
        for (int i = 1; i <= 4; i++) begin
            op(1'b1, MODE_SHL, 1'b0, 1'b0, 4'b0000);
            check("b2b.cnt", 32'(shift_cnt), 32'(i % 4));
            check("b2b.wv", 32'(word_valid), 32'(i == 4));
        end
        check("b2b.pout", 32'(pout), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_univ_shift_reg
`default_nettype wire
